// File: rtl/uart_rx.sv
// uart_rx: oversampling-free UART receiver with start validation, framing/overrun flags and valid/ready output
module uart_rx #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD_RATE  = 115200,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_i,
  input  logic                  ready_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  valid_o,
  output logic                  frame_err_o,
  output logic                  overrun_o,
  output logic                  busy_o
);
  localparam int BAUD_DIV = CLK_FREQ / BAUD_RATE;
  localparam int HALF_DIV = BAUD_DIV / 2;
  localparam int CW       = $clog2(BAUD_DIV);
  localparam int BW       = $clog2(DATA_WIDTH) + 1;

  if (BAUD_DIV < 4) begin : g_bad_div
    $error("uart_rx: BAUD_DIV must be at least 4");
  end
  if (DATA_WIDTH < 1 || DATA_WIDTH > 16) begin : g_bad_width
    $error("uart_rx: DATA_WIDTH must be 1..16");
  end

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BRK} state_t;

  state_t                r_state, w_next;
  logic                  r_s1, r_rx;
  logic [CW-1:0]         r_cnt;
  logic [BW-1:0]         r_bits;
  logic [DATA_WIDTH-1:0] r_shift;
  logic                  r_done;
  logic                  w_half, w_full, w_bit, w_ok, w_err, w_hold;

  assign w_half = r_cnt == CW'(HALF_DIV - 1);
  assign w_full = r_cnt == CW'(BAUD_DIV - 1);
  assign w_hold = valid_o && !ready_i;
  assign busy_o = r_state != S_IDLE;

  // two-flop synchroniser, idles high so reset does not look like a start edge
  always_ff @(posedge clk or posedge rst)
    if (rst) {r_s1, r_rx} <= 2'b11;
    else     {r_s1, r_rx} <= {rx_i, r_s1};

  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;

  // next state and sample strobes
  always_comb begin
    w_next = r_state;
    w_bit  = 1'b0;
    w_ok   = 1'b0;
    w_err  = 1'b0;
    case (r_state)
      S_IDLE:  if (!r_rx) w_next = S_START;
      S_START: if (w_half) w_next = r_rx ? S_IDLE : S_DATA;
      S_DATA:  if (w_full) begin
        w_bit = 1'b1;
        if (r_bits == BW'(DATA_WIDTH - 1)) w_next = S_STOP;
      end
      S_STOP:  if (w_full) begin
        w_ok   = r_rx;
        w_err  = !r_rx;
        w_next = r_rx ? S_IDLE : S_BRK;
      end
      S_BRK:   if (r_rx) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // baud counter aligned to the start edge and restarted every bit; bit counter lives only in DATA
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_cnt  <= '0;
      r_bits <= '0;
    end else begin
      r_cnt  <= (w_next != r_state || w_bit) ? '0 : r_cnt + 1'b1;
      r_bits <= (r_state != S_DATA) ? '0 : (w_bit ? r_bits + 1'b1 : r_bits);
    end

  // LSB-first data arrives at the MSB and shifts right
  always_ff @(posedge clk or posedge rst)
    if (rst)        r_shift <= '0;
    else if (w_bit) r_shift <= DATA_WIDTH'({r_rx, r_shift} >> 1);

  // output handshake: a completing handshake frees the slot for a word landing in the same cycle
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_done      <= 1'b0;
      data_o      <= '0;
      valid_o     <= 1'b0;
      frame_err_o <= 1'b0;
      overrun_o   <= 1'b0;
    end else begin
      r_done      <= w_ok;
      frame_err_o <= w_err;
      overrun_o   <= r_done && w_hold;
      if (r_done && !w_hold) begin
        data_o  <= r_shift;
        valid_o <= 1'b1;
      end else if (valid_o && ready_i) valid_o <= 1'b0;
    end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: randomized frame stimulus against a word-queue reference model
module tb_uart_rx;
  logic       clk = 1'b0, rst = 1'b1, rx = 1'b1, rx2 = 1'b1, ready = 1'b1;
  logic [7:0] data, data2;
  logic       valid, ferr, ovr, busy, valid2, ferr2, ovr2, busy2;
  int         n_chk = 0, n_pass = 0, cyc = 0;
  int         t0 = 0, t2 = 0, rise = 0, rise2 = 0;
  int         n_ferr = 0, n_ovr = 0, n_vcyc = 0, n_unstable = 0;
  logic       vq = 1'b0, vq2 = 1'b0;
  logic [7:0] dq = '0;
  logic [7:0] got[$], got2[$], exp_q[$], exp2[$];

  localparam int B  = 16;
  localparam int BD = 100_000_000 / 115200;

  uart_rx #(.CLK_FREQ(16), .BAUD_RATE(1), .DATA_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .rx_i(rx), .ready_i(ready), .data_o(data),
    .valid_o(valid), .frame_err_o(ferr), .overrun_o(ovr), .busy_o(busy));

  uart_rx dut_d (
    .clk(clk), .rst(rst), .rx_i(rx2), .ready_i(1'b1), .data_o(data2),
    .valid_o(valid2), .frame_err_o(ferr2), .overrun_o(ovr2), .busy_o(busy2));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (valid) begin
      n_vcyc++;
      if (vq && data !== dq) n_unstable++;
      if (!vq) rise = cyc;
      if (ready) got.push_back(data);
    end
    vq = valid;
    dq = data;
    if (ferr) n_ferr++;
    if (ovr) n_ovr++;
    if (valid2 && !vq2) begin
      rise2 = cyc;
      got2.push_back(data2);
    end
    vq2 = valid2;
    if (ferr2 || ovr2) n_ferr++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic drv(input bit ln, input logic v);
    if (ln) rx2 = v;
    else    rx  = v;
  endtask

  task automatic send(input bit ln, input int div, input logic [7:0] d, input int stop_low);
    drv(ln, 1'b0);
    if (ln) t2 = cyc;
    else    t0 = cyc;
    step(div);
    for (int i = 0; i < 8; i++) begin
      drv(ln, d[i]);
      step(div);
    end
    if (stop_low > 0) begin
      drv(ln, 1'b0);
      step(stop_low);
    end else begin
      drv(ln, 1'b1);
      step(div);
    end
  endtask

  task automatic flush(input string tag);
    check({tag, "_count"}, got.size(), exp_q.size());
    while (got.size() > 0 && exp_q.size() > 0) check({tag, "_word"}, got.pop_front(), exp_q.pop_front());
    got.delete();
    exp_q.delete();
  endtask

  int lat, lat_d, fe0, ov0, vc0;
  logic [7:0] w;

  initial begin
    lat   = 2 + 1 + B / 2 + 8 * B + B + 1;
    lat_d = 2 + 1 + BD / 2 + 8 * BD + BD + 1;
    step(3);
    check("reset_outs", {data, valid, ferr, ovr, busy}, 0);
    check("reset_outs_d", {data2, valid2, ferr2, ovr2, busy2}, 0);
    rst = 1'b0;
    step(5);

    send(0, B, 8'hA5, 0);
    exp_q.push_back(8'hA5);
    step(20);
    check("latency", rise - t0, lat);
    check("valid_cycles", n_vcyc, 1);
    check("flags_clean", n_ferr + n_ovr, 0);
    flush("a5");

    vc0 = n_vcyc;
    rx = 1'b0;
    step(4);
    check("glitch_busy", busy, 1);
    rx = 1'b1;
    step(30);
    check("glitch_idle", busy, 0);
    check("glitch_novalid", n_vcyc - vc0, 0);
    check("glitch_noferr", n_ferr, 0);

    fe0 = n_ferr;
    send(0, B, 8'h3C, 20);
    check("brk_busy", busy, 1);
    check("ferr_pulse", n_ferr - fe0, 1);
    rx = 1'b1;
    step(10);
    check("brk_release", busy, 0);
    send(0, B, 8'h81, 0);
    exp_q.push_back(8'h81);
    step(20);
    check("ferr_once", n_ferr - fe0, 1);
    flush("after_brk");

    ov0 = n_ovr;
    ready = 1'b0;
    send(0, B, 8'h11, 0);
    send(0, B, 8'h22, 0);
    step(20);
    check("ovr_data", data, 8'h11);
    check("ovr_valid", valid, 1);
    check("ovr_pulse", n_ovr - ov0, 1);
    ready = 1'b1;
    step(1);
    check("ovr_drain", valid, 0);
    exp_q.push_back(8'h11);
    flush("ovr");

    vc0 = n_vcyc;
    rx = 1'b0;
    step(B);
    rx = 1'b1;
    step(4 * B + B / 2);
    check("pre_rst_busy", busy, 1);
    rst = 1'b1;
    #1;
    check("async_rst_outs", {data, valid, ferr, ovr, busy}, 0);
    step(1);
    rst = 1'b0;
    step(6 * B);
    check("rst_novalid", n_vcyc - vc0, 0);
    send(0, B, 8'h5A, 0);
    exp_q.push_back(8'h5A);
    step(20);
    flush("post_rst");

    fe0 = n_ferr;
    ov0 = n_ovr;
    for (int i = 0; i < 12; i++) begin
      w = 8'($urandom);
      send(0, B, w, 0);
      exp_q.push_back(w);
      step($urandom_range(0, 40));
    end
    step(20);
    flush("rand");
    check("rand_flags", (n_ferr - fe0) + (n_ovr - ov0), 0);

    send(1, BD, 8'h00, 0);
    step(BD);
    send(1, BD, 8'hFF, 0);
    step(200);
    check("dflt_latency", rise2 - t2, lat_d);
    check("dflt_count", got2.size(), 2);
    exp2 = '{8'h00, 8'hFF};
    while (got2.size() > 0 && exp2.size() > 0) check("dflt_word", got2.pop_front(), exp2.pop_front());
    check("data_stable", n_unstable, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
